// File: rtl/pcm_pkg.sv
// Shared PCM definitions and the 16-bit output conversion used by every channel.
// Build option: define PCM_SATURATE_EN to clamp instead of wrapping.
package pcm_pkg;

  localparam int PCM_W = 16;
  localparam logic signed [PCM_W-1:0] PCM_MAX = 16'sh7FFF;
  localparam logic signed [PCM_W-1:0] PCM_MIN = 16'sh8000;

  // Callers sign-extend their accumulator-width value to 32 bits first.
  function automatic logic [PCM_W-1:0] pcm_conv(input logic signed [31:0] v);
    logic [PCM_W-1:0] r;
`ifdef PCM_SATURATE_EN
    if (v > 32'sd32767) begin
      r = PCM_MAX;
    end else if (v < -32'sd32768) begin
      r = PCM_MIN;
    end else begin
      r = v[PCM_W-1:0];
    end
`else
    r = v[PCM_W-1:0];
`endif
    return r;
  endfunction

endpackage

// File: rtl/pcm_decim_chan.sv
// One decimator channel: accumulator, shift/convert, output word register,
// valid/ready handshake and sticky overrun flag.
module pcm_decim_chan
  import pcm_pkg::*;
#(
  parameter int ADW = 12,
  parameter int ACW = ADW + 8
) (
  input  logic             pcm_in_clk,
  input  logic             rst,
  input  logic             acc_en,
  input  logic             dump,
  input  logic [ADW-1:0]   sample,
  input  logic [3:0]       pcm_shift,
  input  logic             out_ready,
  input  logic             overrun_clr,
  output logic             out_valid,
  output logic [PCM_W-1:0] out_word,
  output logic             overrun
);

  // Handshake: a word transfers on any clock where out_valid && out_ready;
  // out_valid never drops without a transfer, and a dump always (re)loads it.
  logic signed [ACW-1:0] acc_q, acc_d;
  logic signed [ACW-1:0] sum, shifted;
  logic [PCM_W-1:0]      word_q, word_d;
  logic                  valid_q, valid_d;
  logic                  ovr_q, ovr_d;

  always_comb begin
    sum     = acc_q + {{(ACW-ADW){sample[ADW-1]}}, sample};
    shifted = sum >>> pcm_shift;
    acc_d   = acc_q;
    word_d  = word_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
    if (overrun_clr) begin
      ovr_d = 1'b0;
    end
    if (dump) begin
      acc_d   = '0;
      word_d  = pcm_conv({{(32-ACW){shifted[ACW-1]}}, shifted});
      valid_d = 1'b1;
      // Overwriting an unaccepted word; set beats a simultaneous clear.
      if (valid_q && !out_ready) begin
        ovr_d = 1'b1;
      end
    end else if (acc_en) begin
      acc_d = sum;
    end
  end

  always_ff @(posedge pcm_in_clk) begin
    if (rst) begin
      acc_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out_valid = valid_q;
  assign out_word  = word_q;
  assign overrun   = ovr_q;

endmodule

// File: rtl/pcm_decimator.sv
// Multi-channel accumulate-and-dump decimator feeding pcmmux_fifo.
// Build option: PCM_SATURATE_EN selects clamping in the 16-bit conversion.
module pcm_decimator
  import pcm_pkg::*;
#(
  parameter int CHANNEL = 3,
  parameter int ADW     = 12,
  parameter int ACW     = ADW + 8
) (
  input  logic                     pcm_in_clk,
  input  logic                     rst,
  input  logic                     adc_valid,
  input  logic [ADW*CHANNEL-1:0]   adc_in,
  output logic [CHANNEL-1:0]       pcm_out_valid,
  input  logic [CHANNEL-1:0]       pcm_out_ready,
  output logic [PCM_W*CHANNEL-1:0] pcm_out,
  input  logic [7:0]               decim_ratio,
  input  logic [3:0]               pcm_shift,
  output logic [CHANNEL-1:0]       overrun,
  input  logic                     overrun_clr
);

  logic [7:0] cnt_q, cnt_d;
  logic       dump, acc_en;

  // >= so that lowering decim_ratio below the running count dumps immediately.
  always_comb begin
    dump   = adc_valid && (cnt_q >= decim_ratio);
    acc_en = adc_valid && !dump;
    cnt_d  = cnt_q;
    if (dump) begin
      cnt_d = '0;
    end else if (acc_en) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge pcm_in_clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  for (genvar k = 0; k < CHANNEL; k++) begin : g_chan
    pcm_decim_chan #(
      .ADW(ADW),
      .ACW(ACW)
    ) u_chan (
      .pcm_in_clk (pcm_in_clk),
      .rst        (rst),
      .acc_en     (acc_en),
      .dump       (dump),
      .sample     (adc_in[ADW*k +: ADW]),
      .pcm_shift  (pcm_shift),
      .out_ready  (pcm_out_ready[k]),
      .overrun_clr(overrun_clr),
      .out_valid  (pcm_out_valid[k]),
      .out_word   (pcm_out[PCM_W*k +: PCM_W]),
      .overrun    (overrun[k])
    );
  end

endmodule

// File: tb/tb_pcm_decimator.sv
// Self-checking bench for pcm_decimator: table-driven frames plus hand-written
// corner sequences, with per-channel expected-word queues.
module tb_pcm_decimator;

  localparam int CH  = 3;
  localparam int ADW = 12;

  logic              pcm_in_clk;
  logic              rst;
  logic              adc_valid;
  logic [ADW*CH-1:0] adc_in;
  logic [CH-1:0]     pcm_out_valid;
  logic [CH-1:0]     pcm_out_ready;
  logic [16*CH-1:0]  pcm_out;
  logic [7:0]        decim_ratio;
  logic [3:0]        pcm_shift;
  logic [CH-1:0]     overrun;
  logic              overrun_clr;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];
  logic [15:0] exp_q2[$];

  pcm_decimator #(.CHANNEL(CH), .ADW(ADW)) dut (
    .pcm_in_clk   (pcm_in_clk),
    .rst          (rst),
    .adc_valid    (adc_valid),
    .adc_in       (adc_in),
    .pcm_out_valid(pcm_out_valid),
    .pcm_out_ready(pcm_out_ready),
    .pcm_out      (pcm_out),
    .decim_ratio  (decim_ratio),
    .pcm_shift    (pcm_shift),
    .overrun      (overrun),
    .overrun_clr  (overrun_clr)
  );

  // Clock / reset
  initial pcm_in_clk = 1'b0;
  always #5 pcm_in_clk = ~pcm_in_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push_exp(input int k, input logic [15:0] v);
    case (k)
      0: exp_q0.push_back(v);
      1: exp_q1.push_back(v);
      default: exp_q2.push_back(v);
    endcase
  endtask

  // Scoreboard: every accepted word is popped and compared.
  always @(negedge pcm_in_clk) begin
    if (!rst) begin
      for (int k = 0; k < CH; k++) begin
        if (pcm_out_valid[k] && pcm_out_ready[k]) begin
          logic [15:0] e;
          logic        have;
          have = 1'b1;
          e    = '0;
          case (k)
            0: if (exp_q0.size() > 0) e = exp_q0.pop_front(); else have = 1'b0;
            1: if (exp_q1.size() > 0) e = exp_q1.pop_front(); else have = 1'b0;
            default: if (exp_q2.size() > 0) e = exp_q2.pop_front(); else have = 1'b0;
          endcase
          checks++;
          if (!have) begin
            errors++;
            $display("FAIL sb_unexpected ch%0d: got word %0h with nothing expected", k, pcm_out[16*k +: 16]);
          end else if (pcm_out[16*k +: 16] !== e) begin
            errors++;
            $display("FAIL sb_word ch%0d: got %0h expected %0h", k, pcm_out[16*k +: 16], e);
          end
        end
      end
    end
  end

  // Driver tasks: inputs change 1 time unit after the active edge.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge pcm_in_clk);
      #1;
    end
  endtask

  task automatic sample(input logic [ADW-1:0] s0, input logic [ADW-1:0] s1, input logic [ADW-1:0] s2);
    adc_in    = {s2, s1, s0};
    adc_valid = 1'b1;
    @(posedge pcm_in_clk);
    #1;
    adc_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  typedef struct packed {
    logic [7:0]     ratio;
    logic [3:0]     shift;
    logic [ADW-1:0] s0, s1, s2;
    logic [15:0]    e0, e1, e2;
  } vec_t;

  vec_t vecs[6];

  initial begin
    rst           = 1'b1;
    adc_valid     = 1'b0;
    adc_in        = '0;
    pcm_out_ready = '1;
    decim_ratio   = 8'd0;
    pcm_shift     = 4'd0;
    overrun_clr   = 1'b0;

    vecs[0] = '{8'd0,   4'd0,  -12'sd5,   12'sd7,    12'sd100,  16'hFFFB, 16'h0007, 16'h0064};
    vecs[1] = '{8'd3,   4'd2,  12'sd5,    -12'sd8,   12'sd2047, 16'h0005, 16'hFFF8, 16'h07FF};
`ifdef PCM_SATURATE_EN
    vecs[2] = '{8'd255, 4'd0,  12'sd2047, -12'sd2048, 12'sd1,   16'h7FFF, 16'h8000, 16'h0100};
`else
    vecs[2] = '{8'd255, 4'd0,  12'sd2047, -12'sd2048, 12'sd1,   16'hFF00, 16'h0000, 16'h0100};
`endif
    vecs[3] = '{8'd255, 4'd4,  12'sd2047, -12'sd2048, 12'sd1,   16'h7FF0, 16'h8000, 16'h0010};
    vecs[4] = '{8'd15,  4'd15, -12'sd1,   12'sd1,    12'sd2047, 16'hFFFF, 16'h0000, 16'h0000};
    vecs[5] = '{8'd7,   4'd1,  -12'sd3,   12'sd3,    12'sd0,    16'hFFF4, 16'h000C, 16'h0000};

    idle(2);
    rst = 1'b0;
    check("reset_valid", 32'(pcm_out_valid), 32'h0);
    check("reset_pcm_out", pcm_out[31:0], 32'h0);
    check("reset_overrun", 32'(overrun), 32'h0);

    // Table-driven frames: two frames per row, random idle gaps between samples.
    for (int r = 0; r < 6; r++) begin
      decim_ratio = vecs[r].ratio;
      pcm_shift   = vecs[r].shift;
      for (int f = 0; f < 2; f++) begin
        for (int i = 0; i <= int'(vecs[r].ratio); i++) begin
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
          if (i == int'(vecs[r].ratio)) begin
            push_exp(0, vecs[r].e0);
            push_exp(1, vecs[r].e1);
            push_exp(2, vecs[r].e2);
          end
          sample(vecs[r].s0, vecs[r].s1, vecs[r].s2);
        end
      end
      idle(2);
    end

    // Ramp 4,8,12,16 with shift 2: word 10 one clock after the 4th sample.
    decim_ratio = 8'd3;
    pcm_shift   = 4'd2;
    sample(12'd4, 12'd0, 12'd0);
    sample(12'd8, 12'd0, 12'd0);
    sample(12'd12, 12'd0, 12'd0);
    check("ramp_no_early_valid", 32'(pcm_out_valid[0]), 32'h0);
    push_exp(0, 16'd10);
    push_exp(1, 16'd0);
    push_exp(2, 16'd0);
    sample(12'd16, 12'd0, 12'd0);
    check("ramp_valid_latency", 32'(pcm_out_valid[0]), 32'h1);
    check("ramp_word", 32'(pcm_out[15:0]), 32'd10);
    idle(2);

    // Overrun on channel 2 with ready held low across two dumps.
    decim_ratio   = 8'd1;
    pcm_shift     = 4'd0;
    pcm_out_ready = 3'b011;
    push_exp(0, 16'd0);
    push_exp(1, 16'd0);
    sample(12'd0, 12'd0, 12'd1);
    sample(12'd0, 12'd0, 12'd2);
    check("ovr_first_no_overrun", 32'(overrun), 32'h0);
    push_exp(0, 16'd0);
    push_exp(1, 16'd0);
    sample(12'd0, 12'd0, 12'd3);
    sample(12'd0, 12'd0, 12'd4);
    idle(1);
    check("ovr_word_overwritten", 32'(pcm_out[47:32]), 32'd7);
    check("ovr_valid_held", 32'(pcm_out_valid[2]), 32'h1);
    check("ovr_flag", 32'(overrun), 32'b100);
    overrun_clr = 1'b1;
    idle(1);
    overrun_clr = 1'b0;
    check("ovr_cleared", 32'(overrun), 32'h0);
    push_exp(2, 16'd7);
    pcm_out_ready = 3'b111;
    idle(2);
    check("ovr_drained", 32'(pcm_out_valid), 32'h0);

    // Reset mid-frame discards the partial sum.
    decim_ratio = 8'd7;
    for (int i = 0; i < 5; i++) sample(12'd1, 12'd1, 12'd1);
    do_reset();
    check("rst_mid_valid", 32'(pcm_out_valid), 32'h0);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        push_exp(0, 16'd8);
        push_exp(1, 16'd8);
        push_exp(2, 16'd8);
      end
      sample(12'd1, 12'd1, 12'd1);
    end
    check("rst_mid_word", 32'(pcm_out[15:0]), 32'd8);
    idle(2);

    // Ratio lowered 7 -> 2 at count 5: next sample dumps, then 3-sample frames.
    decim_ratio = 8'd7;
    for (int i = 0; i < 5; i++) sample(12'd1, 12'd1, 12'd1);
    decim_ratio = 8'd2;
    push_exp(0, 16'd6);
    push_exp(1, 16'd6);
    push_exp(2, 16'd6);
    sample(12'd1, 12'd1, 12'd1);
    check("ratio_drop_dump", 32'(pcm_out[15:0]), 32'd6);
    for (int f = 0; f < 2; f++) begin
      sample(12'd1, 12'd1, 12'd1);
      sample(12'd1, 12'd1, 12'd1);
      check("ratio_drop_no_early", 32'(pcm_out_valid), 32'h0);
      push_exp(0, 16'd3);
      push_exp(1, 16'd3);
      push_exp(2, 16'd3);
      sample(12'd1, 12'd1, 12'd1);
      check("ratio_drop_frame", 32'(pcm_out[15:0]), 32'd3);
    end
    idle(3);

    check("sb_drained_ch0", 32'(exp_q0.size()), 32'd0);
    check("sb_drained_ch1", 32'(exp_q1.size()), 32'd0);
    check("sb_drained_ch2", 32'(exp_q2.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
